// File: rtl/memory_register_read_stage.sv
// Memory-pipe register-read stage: latches issued memory ops per lane, reads the
// physical register file with writeback bypass, and applies stall/clear/selective flush.
module memory_register_read_stage #(
    parameter int LANES    = 2,
    parameter int AL_PTR_W = 6,
    parameter int IQ_PTR_W = 4,
    parameter int PREG_W   = 7,
    parameter int DATA_W   = 32,
    parameter int WB_PORTS = 2,
    parameter int CNT_W    = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           stall,
    input  logic                           clear,
    input  logic [LANES-1:0]               in_valid,
    input  logic [LANES-1:0]               in_replay,
    input  logic [LANES*IQ_PTR_W-1:0]      in_iq_ptr,
    input  logic [LANES*AL_PTR_W-1:0]      in_al_ptr,
    input  logic [LANES*PREG_W-1:0]        in_src_a,
    input  logic [LANES*PREG_W-1:0]        in_src_b,
    input  logic                           flush_req,
    input  logic [AL_PTR_W-1:0]            flush_head,
    input  logic [AL_PTR_W-1:0]            flush_tail,
    input  logic                           flush_all,
    output logic [2*LANES*PREG_W-1:0]      rf_raddr,
    input  logic [2*LANES*DATA_W-1:0]      rf_rdata,
    input  logic [WB_PORTS-1:0]            wb_valid,
    input  logic [WB_PORTS*PREG_W-1:0]     wb_preg,
    input  logic [WB_PORTS*DATA_W-1:0]     wb_data,
    output logic [LANES-1:0]               out_valid,
    output logic [LANES-1:0]               out_replay,
    output logic [LANES*IQ_PTR_W-1:0]      out_iq_ptr,
    output logic [LANES*AL_PTR_W-1:0]      out_al_ptr,
    output logic [LANES*DATA_W-1:0]        out_op_a,
    output logic [LANES*DATA_W-1:0]        out_op_b,
    output logic [CNT_W-1:0]               flush_count
);

    localparam logic [CNT_W:0] CNT_MAX = {1'b0, {CNT_W{1'b1}}};

    logic [LANES-1:0]          valid_q,   valid_d;
    logic [LANES-1:0]          replay_q,  replay_d;
    logic [LANES*IQ_PTR_W-1:0] iq_ptr_q,  iq_ptr_d;
    logic [LANES*AL_PTR_W-1:0] al_ptr_q,  al_ptr_d;
    logic [LANES*PREG_W-1:0]   src_a_q,   src_a_d;
    logic [LANES*PREG_W-1:0]   src_b_q,   src_b_d;
    logic [CNT_W-1:0]          flush_count_q, flush_count_d;
    logic [LANES-1:0]          kill;
    logic                      capture;

    // Range is [head, tail) on the circular active list; head==tail means empty.
    function automatic logic flush_hit(
        input logic [AL_PTR_W-1:0] p,
        input logic [AL_PTR_W-1:0] head,
        input logic [AL_PTR_W-1:0] tail,
        input logic                req,
        input logic                all
    );
        if (!req)        return 1'b0;
        if (all)         return 1'b1;
        if (head < tail) return (p >= head) && (p < tail);
        if (head > tail) return (p >= head) || (p < tail);
        return 1'b0;
    endfunction

    // Lowest-numbered matching writeback port wins, so scan from the top down.
    function automatic logic [DATA_W-1:0] sel_operand(
        input logic [PREG_W-1:0]          src,
        input logic [DATA_W-1:0]          rdata,
        input logic [WB_PORTS-1:0]        wv,
        input logic [WB_PORTS*PREG_W-1:0] wp,
        input logic [WB_PORTS*DATA_W-1:0] wd
    );
        logic [DATA_W-1:0] sel;
        sel = rdata;
        for (int k = WB_PORTS - 1; k >= 0; k--) begin
            if (wv[k] && (wp[k*PREG_W +: PREG_W] == src)) begin
                sel = wd[k*DATA_W +: DATA_W];
            end
        end
        return sel;
    endfunction

    assign capture = !clear && !stall;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [PREG_W-1:0] src_a;
            logic [PREG_W-1:0] src_b;

            assign src_a = src_a_q[gi*PREG_W +: PREG_W];
            assign src_b = src_b_q[gi*PREG_W +: PREG_W];

            assign kill[gi] = flush_hit(al_ptr_q[gi*AL_PTR_W +: AL_PTR_W],
                                        flush_head, flush_tail, flush_req, flush_all);

            assign valid_d[gi] = clear   ? 1'b0 :
                                 !stall  ? in_valid[gi] :
                                           (valid_q[gi] && !kill[gi]);

            assign rf_raddr[gi*2*PREG_W + PREG_W +: PREG_W] = src_a;
            assign rf_raddr[gi*2*PREG_W +: PREG_W]          = src_b;

            assign out_op_a[gi*DATA_W +: DATA_W] =
                sel_operand(src_a, rf_rdata[gi*2*DATA_W + DATA_W +: DATA_W],
                            wb_valid, wb_preg, wb_data);
            assign out_op_b[gi*DATA_W +: DATA_W] =
                sel_operand(src_b, rf_rdata[gi*2*DATA_W +: DATA_W],
                            wb_valid, wb_preg, wb_data);

            assign out_valid[gi] = valid_q[gi] && !stall && !clear && !kill[gi];
        end
    endgenerate

    assign replay_d = capture ? in_replay : replay_q;
    assign iq_ptr_d = capture ? in_iq_ptr : iq_ptr_q;
    assign al_ptr_d = capture ? in_al_ptr : al_ptr_q;
    assign src_a_d  = capture ? in_src_a  : src_a_q;
    assign src_b_d  = capture ? in_src_b  : src_b_q;

    always_comb begin
        logic [CNT_W:0] kill_sum;
        logic [CNT_W:0] total;
        kill_sum      = '0;
        flush_count_d = flush_count_q;
        for (int l = 0; l < LANES; l++) begin
            kill_sum = kill_sum + {{CNT_W{1'b0}}, (valid_q[l] && kill[l])};
        end
        total = {1'b0, flush_count_q} + kill_sum;
        if (!clear) begin
            flush_count_d = (total > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : total[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q       <= '0;
            replay_q      <= '0;
            iq_ptr_q      <= '0;
            al_ptr_q      <= '0;
            src_a_q       <= '0;
            src_b_q       <= '0;
            flush_count_q <= '0;
        end else begin
            valid_q       <= valid_d;
            replay_q      <= replay_d;
            iq_ptr_q      <= iq_ptr_d;
            al_ptr_q      <= al_ptr_d;
            src_a_q       <= src_a_d;
            src_b_q       <= src_b_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign out_replay  = replay_q;
    assign out_iq_ptr  = iq_ptr_q;
    assign out_al_ptr  = al_ptr_q;
    assign flush_count = flush_count_q;

endmodule

// File: tb/tb_memory_register_read_stage.sv
// Bench for memory_register_read_stage: directed steps plus random traffic checked
// against a per-lane behavioural model with a modular-distance flush rule.
module tb_memory_register_read_stage;

    localparam int L  = 2;
    localparam int AW = 6;
    localparam int IW = 4;
    localparam int PW = 7;
    localparam int DW = 32;
    localparam int WP = 2;
    localparam int CW = 16;

    logic              clk, rst, stall, clear;
    logic [L-1:0]      in_valid, in_replay;
    logic [L*IW-1:0]   in_iq_ptr;
    logic [L*AW-1:0]   in_al_ptr;
    logic [L*PW-1:0]   in_src_a, in_src_b;
    logic              flush_req, flush_all;
    logic [AW-1:0]     flush_head, flush_tail;
    logic [2*L*PW-1:0] rf_raddr;
    logic [2*L*DW-1:0] rf_rdata;
    logic [WP-1:0]     wb_valid;
    logic [WP*PW-1:0]  wb_preg;
    logic [WP*DW-1:0]  wb_data;
    logic [L-1:0]      out_valid, out_replay;
    logic [L*IW-1:0]   out_iq_ptr;
    logic [L*AW-1:0]   out_al_ptr;
    logic [L*DW-1:0]   out_op_a, out_op_b;
    logic [CW-1:0]     flush_count;

    memory_register_read_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .clear(clear),
        .in_valid(in_valid), .in_replay(in_replay), .in_iq_ptr(in_iq_ptr),
        .in_al_ptr(in_al_ptr), .in_src_a(in_src_a), .in_src_b(in_src_b),
        .flush_req(flush_req), .flush_head(flush_head), .flush_tail(flush_tail),
        .flush_all(flush_all), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .wb_valid(wb_valid), .wb_preg(wb_preg), .wb_data(wb_data),
        .out_valid(out_valid), .out_replay(out_replay), .out_iq_ptr(out_iq_ptr),
        .out_al_ptr(out_al_ptr), .out_op_a(out_op_a), .out_op_b(out_op_b),
        .flush_count(flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench-side register file contents, indexed by physical register number.
    logic [DW-1:0] regfile [128];

    always_comb begin
        rf_rdata = '0;
        for (int l = 0; l < L; l++) begin
            rf_rdata[l*2*DW + DW +: DW] = regfile[rf_raddr[l*2*PW + PW +: PW]];
            rf_rdata[l*2*DW +: DW]      = regfile[rf_raddr[l*2*PW +: PW]];
        end
    end

    int n_cmp  = 0;
    int n_fail = 0;

    bit m_valid [L];
    bit m_replay[L];
    int m_iq    [L];
    int m_al    [L];
    int m_srca  [L];
    int m_srcb  [L];
    int m_cnt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit fpred(input int p);
        int dp, dt;
        if (!flush_req) return 1'b0;
        if (flush_all)  return 1'b1;
        dp = (p - int'(flush_head) + 64) % 64;
        dt = (int'(flush_tail) - int'(flush_head) + 64) % 64;
        return dp < dt;
    endfunction

    function automatic logic [DW-1:0] exp_operand(input int src);
        for (int k = 0; k < WP; k++) begin
            if (wb_valid[k] && int'(wb_preg[k*PW +: PW]) == src) return wb_data[k*DW +: DW];
        end
        return regfile[src];
    endfunction

    task automatic model_reset();
        for (int l = 0; l < L; l++) begin
            m_valid[l] = 0; m_replay[l] = 0; m_iq[l] = 0;
            m_al[l] = 0; m_srca[l] = 0; m_srcb[l] = 0;
        end
        m_cnt = 0;
    endtask

    task automatic check_all();
        logic [L-1:0]      ev, er;
        logic [L*IW-1:0]   ei;
        logic [L*AW-1:0]   ea;
        logic [L*DW-1:0]   eoa, eob;
        logic [2*L*PW-1:0] eaddr;
        for (int l = 0; l < L; l++) begin
            ev[l] = m_valid[l] && !stall && !clear && !fpred(m_al[l]);
            er[l] = m_replay[l];
            ei[l*IW +: IW] = IW'(m_iq[l]);
            ea[l*AW +: AW] = AW'(m_al[l]);
            eoa[l*DW +: DW] = exp_operand(m_srca[l]);
            eob[l*DW +: DW] = exp_operand(m_srcb[l]);
            eaddr[l*2*PW + PW +: PW] = PW'(m_srca[l]);
            eaddr[l*2*PW +: PW]      = PW'(m_srcb[l]);
        end
        check("out_valid",   64'(out_valid),   64'(ev));
        check("out_replay",  64'(out_replay),  64'(er));
        check("out_iq_ptr",  64'(out_iq_ptr),  64'(ei));
        check("out_al_ptr",  64'(out_al_ptr),  64'(ea));
        check("out_op_a",    64'(out_op_a),    64'(eoa));
        check("out_op_b",    64'(out_op_b),    64'(eob));
        check("rf_raddr",    64'(rf_raddr),    64'(eaddr));
        check("flush_count", 64'(flush_count), 64'(m_cnt));
        $display("cyc t=%0t stall=%0b clear=%0b freq=%0b all=%0b h=%0d t=%0d out_valid=%b cnt=%0d",
                 $time, stall, clear, flush_req, flush_all, flush_head, flush_tail, out_valid, flush_count);
    endtask

    // Called after a settle: advance the model from pre-edge inputs, then take the edge.
    task automatic edge_step();
        int kills;
        bit f [L];
        kills = 0;
        for (int l = 0; l < L; l++) begin
            f[l] = fpred(m_al[l]);
            if (m_valid[l] && f[l]) kills++;
        end
        if (!clear) m_cnt = (m_cnt + kills > 65535) ? 65535 : m_cnt + kills;
        for (int l = 0; l < L; l++) begin
            if (clear) begin
                m_valid[l] = 0;
            end else if (!stall) begin
                m_valid[l]  = in_valid[l];
                m_replay[l] = in_replay[l];
                m_iq[l]     = int'(in_iq_ptr[l*IW +: IW]);
                m_al[l]     = int'(in_al_ptr[l*AW +: AW]);
                m_srca[l]   = int'(in_src_a[l*PW +: PW]);
                m_srcb[l]   = int'(in_src_b[l*PW +: PW]);
            end else begin
                m_valid[l] = m_valid[l] && !f[l];
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #4;
        check_all();
    endtask

    task automatic cycle();
        settle();
        edge_step();
    endtask

    task automatic set_lane(input int l, input bit v, input bit rp, input int iq,
                            input int al, input int a, input int b);
        in_valid[l]            = v;
        in_replay[l]           = rp;
        in_iq_ptr[l*IW +: IW]  = IW'(iq);
        in_al_ptr[l*AW +: AW]  = AW'(al);
        in_src_a[l*PW +: PW]   = PW'(a);
        in_src_b[l*PW +: PW]   = PW'(b);
    endtask

    task automatic no_flush();
        flush_req = 0; flush_all = 0; flush_head = '0; flush_tail = '0;
    endtask

    int saved_cnt;

    initial begin
        for (int i = 0; i < 128; i++) regfile[i] = $urandom;
        rst = 1; stall = 0; clear = 0;
        in_valid = '0; in_replay = '0; in_iq_ptr = '0; in_al_ptr = '0;
        in_src_a = '0; in_src_b = '0; wb_valid = '0; wb_preg = '0; wb_data = '0;
        no_flush();
        model_reset();
        @(posedge clk); #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_flush_count", 64'(flush_count), 64'd0);
        rst = 0;

        // Basic capture: both lanes valid, operands from the register file.
        set_lane(0, 1, 0, 1, 3, 20, 21);
        set_lane(1, 1, 1, 2, 4, 22, 23);
        cycle();
        settle();
        check("basic_valid", 64'(out_valid), 64'd3);
        check("basic_op_a0", 64'(out_op_a[DW-1:0]), 64'(regfile[20]));
        check("basic_op_b1", 64'(out_op_b[2*DW-1:DW]), 64'(regfile[23]));

        // Bypass: both writeback ports target src_a=9; port 0 wins.
        set_lane(0, 1, 0, 3, 7, 9, 30);
        set_lane(1, 1, 0, 4, 8, 9, 31);
        edge_step();
        wb_valid = 2'b11;
        wb_preg  = {PW'(9), PW'(9)};
        wb_data  = {32'h0000BBBB, 32'h0000AAAA};
        settle();
        check("bypass_lo_a0", 64'(out_op_a[DW-1:0]), 64'h0000AAAA);
        check("bypass_lo_a1", 64'(out_op_a[2*DW-1:DW]), 64'h0000AAAA);
        wb_valid = 2'b00;
        settle();
        check("bypass_off_a0", 64'(out_op_a[DW-1:0]), 64'(regfile[9]));

        // Stall for three cycles with lane0 al_ptr=5; fields held on release.
        set_lane(0, 1, 1, 6, 5, 40, 41);
        set_lane(1, 0, 0, 0, 0, 42, 43);
        edge_step();
        stall = 1;
        set_lane(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            settle();
            check("stall_no_valid", 64'(out_valid), 64'd0);
            edge_step();
        end
        stall = 0;
        settle();
        check("stall_release_valid", 64'(out_valid[0]), 64'd1);
        check("stall_release_al", 64'(out_al_ptr[AW-1:0]), 64'd5);
        check("stall_release_iq", 64'(out_iq_ptr[IW-1:0]), 64'd6);

        // Stall with a wrapping flush range 60..2: al 62 killed, al 10 survives.
        set_lane(0, 1, 0, 1, 62, 1, 2);
        set_lane(1, 1, 0, 2, 10, 3, 4);
        edge_step();
        saved_cnt = int'(flush_count);
        stall = 1; flush_req = 1; flush_head = 6'd60; flush_tail = 6'd2;
        cycle();
        no_flush(); stall = 0;
        settle();
        check("wrap_flush_valid", 64'(out_valid), 64'b10);
        check("wrap_flush_cnt", 64'(flush_count), 64'(saved_cnt + 1));

        // flush_all with two valid lanes counts two.
        set_lane(0, 1, 0, 1, 11, 1, 2);
        set_lane(1, 1, 0, 2, 12, 3, 4);
        edge_step();
        saved_cnt = int'(flush_count);
        flush_req = 1; flush_all = 1;
        settle();
        check("flush_all_valid", 64'(out_valid), 64'd0);
        edge_step();
        no_flush();
        settle();
        check("flush_all_cnt", 64'(flush_count), 64'(saved_cnt + 2));

        // clear with stall and a pending flush: valid drops, count untouched.
        edge_step();
        saved_cnt = int'(flush_count);
        clear = 1; stall = 1; flush_req = 1; flush_all = 1;
        cycle();
        clear = 0; stall = 0; no_flush(); in_valid = '0;
        settle();
        check("clear_valid", 64'(out_valid), 64'd0);
        check("clear_cnt", 64'(flush_count), 64'(saved_cnt));
        edge_step();

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            stall = ($urandom_range(0, 9) < 3);
            clear = ($urandom_range(0, 9) == 0);
            flush_req  = ($urandom_range(0, 9) < 3);
            flush_all  = ($urandom_range(0, 9) < 2);
            flush_head = AW'($urandom);
            flush_tail = AW'($urandom);
            for (int l = 0; l < L; l++)
                set_lane(l, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 15),
                         $urandom_range(0, 63), $urandom_range(0, 15), $urandom_range(0, 15));
            wb_valid = WP'($urandom);
            for (int k = 0; k < WP; k++) begin
                wb_preg[k*PW +: PW] = PW'($urandom_range(0, 15));
                wb_data[k*DW +: DW] = $urandom;
            end
            cycle();
        end
        wb_valid = '0; stall = 0; clear = 0;

        // Saturation: flush both lanes every cycle until the counter pegs.
        set_lane(0, 1, 0, 0, 0, 0, 0);
        set_lane(1, 1, 0, 0, 1, 0, 0);
        flush_req = 1; flush_all = 1;
        for (int i = 0; i < 32800; i++) edge_step();
        settle();
        check("sat_cnt", 64'(flush_count), 64'hFFFF);
        edge_step();
        settle();
        check("sat_hold_cnt", 64'(flush_count), 64'hFFFF);
        no_flush();
        edge_step();

        // Asynchronous reset mid-cycle with valid ops in flight.
        settle();
        check("pre_rst_valid", 64'(out_valid), 64'd3);
        #2;
        rst = 1;
        #1;
        check("async_rst_valid", 64'(out_valid), 64'd0);
        check("async_rst_cnt", 64'(flush_count), 64'd0);
        model_reset();
        @(posedge clk); #1;
        rst = 0;
        in_valid = '0;
        cycle();
        settle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
